kcpsm3_int_ctrl: RTL and testbench



---
 rtl/kcpsm3_int_ctrl.sv | 83 ++++++++
 tb/tb_kcpsm3_int_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kcpsm3_int_ctrl.sv
// kcpsm3_int_ctrl: prioritised eight-source interrupt controller for KCPSM3 (PicoBlaze)
module kcpsm3_int_ctrl #(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       port_id,
    input  logic             write_strobe,
    input  logic             read_strobe,
    input  logic [7:0]       out_port,
    output logic [7:0]       in_port,
    output logic             interrupt,
    input  logic             interrupt_ack
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
    state_t state_q, state_d;
    logic [N_SRC-1:0] irq_q, pend_q, pend_d, mask_q, mask_d, rise, active, clr;
    logic [2:0] vec_q, vec_d, win;
    logic [7:0] in_port_q, in_port_d;
    logic interrupt_q, interrupt_d;
    logic hit, wr_pend, wr_mask, wr_eoi;
    logic unused;
    assign unused    = ^{read_strobe, out_port};
    assign in_port   = in_port_q;
    assign interrupt = interrupt_q;
    always_comb begin
        hit     = port_id[7:2] == BASE_ADDR[7:2];
        wr_pend = write_strobe && hit && port_id[1:0] == 2'd0;
        wr_mask = write_strobe && hit && port_id[1:0] == 2'd1;
        wr_eoi  = write_strobe && hit && port_id[1:0] == 2'd3;
        rise    = irq_src & ~irq_q;
        active  = pend_q & mask_q;
        win     = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (active[i]) win = 3'(i);
        state_d = state_q;
        vec_d   = vec_q;
        clr     = wr_pend ? out_port[N_SRC-1:0] : '0;
        case (state_q)
            IDLE: if (active != '0) state_d = REQ;
            REQ: begin
                if (interrupt_ack) begin
                    state_d = SVC;
                    vec_d   = win;
                    clr     = clr | (N_SRC'(1) << win);
                end else if (active == '0) begin
                    state_d = IDLE;
                end
            end
            SVC: if (wr_eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a new edge wins over any clear in the same cycle
        pend_d      = (pend_q & ~clr) | rise;
        mask_d      = wr_mask ? out_port[N_SRC-1:0] : mask_q;
        interrupt_d = state_d == REQ;
        in_port_d   = !hit                 ? 8'h00 :
                      port_id[1:0] == 2'd0 ? 8'(pend_q) :
                      port_id[1:0] == 2'd1 ? 8'(mask_q) :
                      port_id[1:0] == 2'd2 ? {state_q == SVC, 4'b0000, vec_q} : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            irq_q       <= '1;
            pend_q      <= '0;
            mask_q      <= '0;
            vec_q       <= '0;
            in_port_q   <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_src;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            vec_q       <= vec_d;
            in_port_q   <= in_port_d;
            interrupt_q <= interrupt_d;
        end
    end
endmodule

// File: tb/tb_kcpsm3_int_ctrl.sv
// tb_kcpsm3_int_ctrl: vector table, directed handshake sequences and random traffic against a reference model
module tb_kcpsm3_int_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq = 8'h00;
    logic [7:0] pid = 8'h00;
    logic       ws  = 1'b0;
    logic       rs  = 1'b0;
    logic [7:0] op  = 8'h00;
    logic       ack = 1'b0;
    logic [7:0] in_port;
    logic       interrupt;
    int nchk = 0;
    int nerr = 0;

    kcpsm3_int_ctrl #(.N_SRC(8), .BASE_ADDR(8'hE0)) dut (
        .clk(clk), .reset(rst), .irq_src(irq), .port_id(pid),
        .write_strobe(ws), .read_strobe(rs), .out_port(op),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(ack)
    );

    always #5 clk = ~clk;

    // reference model: spec-level phase 0 idle, 1 requesting, 2 in service
    logic [7:0] m_prev = 8'hFF, m_pend = 8'h00, m_mask = 8'h00, m_in = 8'h00;
    int         m_ph = 0, m_vec = 0;
    logic       m_int = 1'b0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [2:0] v;
        v = 3'(m_vec);
        if (a == 8'hE0) return m_pend;
        if (a == 8'hE1) return m_mask;
        if (a == 8'hE2) return {m_ph == 2, 4'b0000, v};
        return 8'h00;
    endfunction

    task automatic model_step();
        logic [7:0] rise, act, np, nm;
        int nph;
        if (rst) begin
            m_prev = 8'hFF; m_pend = 0; m_mask = 0; m_ph = 0; m_vec = 0; m_int = 0; m_in = 0;
        end else begin
            m_in   = model_read(pid);
            rise   = irq & ~m_prev;
            m_prev = irq;
            act    = m_pend & m_mask;
            np     = m_pend;
            nm     = m_mask;
            nph    = m_ph;
            if (ws && pid == 8'hE0) np = np & ~op;
            if (ws && pid == 8'hE1) nm = op;
            if (m_ph == 0 && act != 0) nph = 1;
            else if (m_ph == 1 && ack) begin
                m_vec = lowest(act);
                np[m_vec] = 1'b0;
                nph = 2;
            end else if (m_ph == 1 && act == 0) nph = 0;
            else if (m_ph == 2 && ws && pid == 8'hE3) nph = 0;
            m_pend = np | rise;
            m_mask = nm;
            m_ph   = nph;
            m_int  = nph == 1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_interrupt", {7'b0, interrupt}, {7'b0, m_int});
        chk("model_in_port", in_port, m_in);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        pid = a; ws = 1'b1; op = d;
        tick();
        ws = 1'b0; op = 8'h00;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        pid = a; rs = 1'b1;
        tick();
        rs = 1'b0;
        chk(name, in_port, exp);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic chk_int(input string name, input logic exp);
        chk(name, {7'b0, interrupt}, {7'b0, exp});
    endtask

    typedef struct {
        logic [7:0] pid;
        logic       ws;
        logic [7:0] op;
        logic [7:0] irq;
        logic       ack;
        logic       exp_int;
        logic [7:0] exp_in;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{8'hE1, 1, 8'hA5, 8'h00, 0, 0, 8'h00};
        tbl[1]  = '{8'hE1, 0, 8'h00, 8'h00, 0, 0, 8'hA5};
        tbl[2]  = '{8'hE0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tbl[3]  = '{8'hE3, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tbl[4]  = '{8'h10, 1, 8'hFF, 8'h00, 0, 0, 8'h00};
        tbl[5]  = '{8'hE1, 0, 8'h00, 8'h00, 0, 0, 8'hA5};
        tbl[6]  = '{8'hE2, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tbl[7]  = '{8'hE1, 0, 8'h00, 8'h02, 0, 0, 8'hA5};
        tbl[8]  = '{8'hE0, 0, 8'h00, 8'h00, 0, 0, 8'h02};
        tbl[9]  = '{8'hE0, 0, 8'h00, 8'h01, 0, 0, 8'h02};
        tbl[10] = '{8'hE0, 0, 8'h00, 8'h00, 0, 1, 8'h03};
        tbl[11] = '{8'hE2, 0, 8'h00, 8'h00, 1, 0, 8'h00};
        tbl[12] = '{8'hE2, 0, 8'h00, 8'h00, 0, 0, 8'h80};
        tbl[13] = '{8'hE0, 0, 8'h00, 8'h00, 0, 0, 8'h02};
        tbl[14] = '{8'hE3, 1, 8'h00, 8'h00, 0, 0, 8'h00};
        tbl[15] = '{8'hE2, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tbl[16] = '{8'hE0, 1, 8'h02, 8'h00, 0, 0, 8'h02};
        tbl[17] = '{8'hE0, 0, 8'h00, 8'h00, 0, 0, 8'h00};

        // reset with a line held high: no spurious edge afterwards
        rst = 1'b1; irq = 8'h01;
        ticks(2);
        chk_int("reset_interrupt", 1'b0);
        chk("reset_in_port", in_port, 8'h00);
        rst = 1'b0;
        wr(8'hE1, 8'h01);
        ticks(3);
        chk_int("held_line_no_irq", 1'b0);
        rd("held_line_pend", 8'hE0, 8'h00);
        irq = 8'h00;
        tick();

        // priority: sources 5 and 2 together
        wr(8'hE1, 8'hFF);
        irq = 8'h24;
        tick();
        irq = 8'h00;
        chk_int("prio_not_yet", 1'b0);
        tick();
        chk_int("prio_irq_two_cycles", 1'b1);
        do_ack();
        chk_int("prio_ack_drops_irq", 1'b0);
        rd("prio_vec_first", 8'hE2, 8'h82);
        rd("prio_pend_after_ack", 8'hE0, 8'h20);
        wr(8'hE3, 8'h00);
        tick();
        chk_int("prio_reassert_after_eoi", 1'b1);
        do_ack();
        rd("prio_vec_second", 8'hE2, 8'h85);
        wr(8'hE3, 8'h00);
        tick();

        // mask and software drop while requesting
        wr(8'hE1, 8'h00);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        ticks(2);
        chk_int("masked_no_irq", 1'b0);
        rd("masked_pend_set", 8'hE0, 8'h08);
        wr(8'hE1, 8'h08);
        tick();
        chk_int("unmask_irq", 1'b1);
        wr(8'hE0, 8'h08);
        chk_int("drop_irq_still_up", 1'b1);
        tick();
        chk_int("drop_irq_low", 1'b0);
        rd("drop_fsm_idle", 8'hE2, 8'h05);
        do_ack();
        rd("stray_ack_ignored", 8'hE2, 8'h05);

        // set-dominant clear
        pid = 8'hE0; ws = 1'b1; op = 8'h02; irq = 8'h02;
        tick();
        ws = 1'b0; op = 8'h00; irq = 8'h00;
        rd("set_dominates_clear", 8'hE0, 8'h02);
        wr(8'hE0, 8'h02);
        rd("pend_cleared", 8'hE0, 8'h00);

        // edge during service, then reset while requesting
        wr(8'hE1, 8'h01);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        chk_int("svc_req", 1'b1);
        do_ack();
        irq = 8'h01;
        tick();
        irq = 8'h00;
        ticks(2);
        chk_int("svc_edge_held_off", 1'b0);
        wr(8'hE3, 8'h00);
        tick();
        chk_int("svc_eoi_reassert", 1'b1);
        do_ack();
        rd("svc_vec_idx0", 8'hE2, 8'h80);
        wr(8'hE3, 8'h00);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        chk_int("req_before_reset", 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_int("reset_in_req_irq", 1'b0);
        chk("reset_in_req_in_port", in_port, 8'h00);
        rd("reset_pend", 8'hE0, 8'h00);
        rd("reset_mask", 8'hE1, 8'h00);
        rd("reset_vec", 8'hE2, 8'h00);

        // vector table
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pid = tbl[i].pid; ws = tbl[i].ws; op = tbl[i].op;
            irq = tbl[i].irq; ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d_int", i), {7'b0, interrupt}, {7'b0, tbl[i].exp_int});
            chk($sformatf("tbl%0d_in_port", i), in_port, tbl[i].exp_in);
        end
        ws = 1'b0; ack = 1'b0; irq = 8'h00;

        // randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            irq = 8'($urandom);
            ws  = ($urandom_range(0, 3) == 0);
            pid = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hE0 + 8'($urandom_range(0, 3));
            op  = 8'($urandom);
            ack = interrupt ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; ws = 1'b0; ack = 1'b0; irq = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
